// File: rtl/regfile_pkg.sv
// Shared types and helpers for the context-switching register file:
// engine state encoding, context operation codes, special-register
// address offsets and the byte-lane merge used by masked writes.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } ctx_state_e;

  localparam logic CTX_SAVE    = 1'b0;
  localparam logic CTX_RESTORE = 1'b1;

  // Special registers sit directly above the GPRs in the address map
  localparam int unsigned MAR_OFS   = 32'd0;
  localparam int unsigned MPAGE_OFS = 32'd1;
  localparam int unsigned OREG_OFS  = 32'd2;
  localparam int unsigned IREG_OFS  = 32'd3;

  // One byte lane of a masked write: new byte when enabled, old byte otherwise
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    logic [7:0] r;
    if (en) begin
      r = new_b;
    end else begin
      r = old_b;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_ctx_sync2.sv
// Parametrised-width two-flop synchroniser for asynchronous inputs.
module sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= {W{1'b0}};
      sync_r <= {W{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/regfile_ctx.sv
// General-purpose register file with two bypassed combinational read
// ports, one byte-masked write port, a shadow bank filled/drained by a
// sequential save/restore engine, and memory-address, memory-page,
// output and synchronised-input registers mapped above the GPRs.
module regfile_ctx
  import regfile_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int WIDTH = 16,
  parameter int IO_W  = 8,
  parameter int AW    = $clog2(NREGS + 4)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/8-1:0]   wmask,
  input  logic [AW-1:0]        raddr_a,
  input  logic [AW-1:0]        raddr_b,
  output logic [WIDTH-1:0]     rdata_a,
  output logic [WIDTH-1:0]     rdata_b,
  input  logic                 ctx_req,
  input  logic                 ctx_op,
  output logic                 ctx_busy,
  output logic                 ctx_done,
  output logic                 wr_drop,
  output logic [WIDTH-1:0]     mar,
  output logic [IO_W-1:0]      mpage,
  output logic [IO_W-1:0]      oreg,
  output logic                 oreg_stb,
  output logic [IO_W-1:0]      ireg,
  input  logic [IO_W-1:0]      ui_in
);

  localparam int NB = WIDTH / 8;
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [AW-1:0] A_NREGS = AW'(NREGS);
  localparam logic [AW-1:0] A_MAR   = AW'(NREGS + MAR_OFS);
  localparam logic [AW-1:0] A_MPAGE = AW'(NREGS + MPAGE_OFS);
  localparam logic [AW-1:0] A_OREG  = AW'(NREGS + OREG_OFS);
  localparam logic [AW-1:0] A_IREG  = AW'(NREGS + IREG_OFS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

  logic [WIDTH-1:0] gpr_r    [NREGS];
  logic [WIDTH-1:0] shadow_r [NREGS];
  logic [WIDTH-1:0] mar_r;
  logic [IO_W-1:0]  mpage_r;
  logic [IO_W-1:0]  oreg_r;
  logic [IO_W-1:0]  ireg_s;
  logic             oreg_stb_r;
  logic             wr_drop_r;
  logic             ctx_busy_r;
  logic             ctx_done_r;

  ctx_state_e       state_r;
  ctx_state_e       state_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic [IW-1:0]    idx_r;
  logic             op_r;

  logic             copying_s;
  logic             copy_save_s;
  logic             copy_restore_s;
  logic             is_gpr_s;
  logic             gpr_wr_s;
  logic             mar_wr_s;
  logic             mpage_wr_s;
  logic             oreg_wr_s;
  logic             accept_s;
  logic             drop_s;
  logic [WIDTH-1:0] gpr_new_s;
  logic [WIDTH-1:0] mar_new_s;

  // Merge a full word lane by lane under the byte mask
  function automatic logic [WIDTH-1:0] merge_word(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [NB-1:0]    mask);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < NB; i++) begin
      r[8*i +: 8] = merge_byte(old_w[8*i +: 8], new_w[8*i +: 8], mask[i]);
    end
    return r;
  endfunction

  // Input synchroniser feeding the IREG view
  sync2 #(.W(IO_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ui_in),
    .q   (ireg_s)
  );

  // Write decode: which target accepts this cycle's write, and whether it is discarded
  always_comb begin
    copying_s      = (state_r == COPY);
    copy_save_s    = copying_s && (op_r == CTX_SAVE);
    copy_restore_s = copying_s && (op_r == CTX_RESTORE);
    is_gpr_s       = (waddr < A_NREGS);
    gpr_wr_s       = we && is_gpr_s && !copying_s;
    mar_wr_s       = we && (waddr == A_MAR);
    mpage_wr_s     = we && (waddr == A_MPAGE) && wmask[0];
    oreg_wr_s      = we && (waddr == A_OREG) && wmask[0];
    accept_s       = gpr_wr_s || mar_wr_s ||
                     (we && ((waddr == A_MPAGE) || (waddr == A_OREG)));
    drop_s         = we && !accept_s;
    if (is_gpr_s) begin
      gpr_new_s = merge_word(gpr_r[waddr[IW-1:0]], wdata, wmask);
    end else begin
      gpr_new_s = {WIDTH{1'b0}};
    end
    mar_new_s      = merge_word(mar_r, wdata, wmask);
  end

  // Combinational read with write bypass; unmapped addresses read as zero
  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] v;
    v = {WIDTH{1'b0}};
    if (addr < A_NREGS) begin
      if (gpr_wr_s && (waddr == addr)) begin
        v = gpr_new_s;
      end else begin
        v = gpr_r[addr[IW-1:0]];
      end
    end else if (addr == A_MAR) begin
      if (mar_wr_s) begin
        v = mar_new_s;
      end else begin
        v = mar_r;
      end
    end else if (addr == A_MPAGE) begin
      if (mpage_wr_s) begin
        v = WIDTH'(wdata[IO_W-1:0]);
      end else begin
        v = WIDTH'(mpage_r);
      end
    end else if (addr == A_OREG) begin
      if (oreg_wr_s) begin
        v = WIDTH'(wdata[IO_W-1:0]);
      end else begin
        v = WIDTH'(oreg_r);
      end
    end else if (addr == A_IREG) begin
      v = WIDTH'(ireg_s);
    end else begin
      v = {WIDTH{1'b0}};
    end
    return v;
  endfunction

  // Read port A mux
  always_comb begin
    rdata_a = read_port(raddr_a);
  end

  // Read port B mux
  always_comb begin
    rdata_b = read_port(raddr_b);
  end

  // Context engine state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Context engine next state and next-cycle busy/done flags
  always_comb begin
    state_s    = state_r;
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (ctx_req) begin
          state_s    = COPY;
          busy_nxt_s = 1'b1;
        end else begin
          state_s    = IDLE;
        end
      end
      COPY: begin
        if (idx_r == LAST_IDX) begin
          state_s    = DONE;
          done_nxt_s = 1'b1;
        end else begin
          state_s    = COPY;
          busy_nxt_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Copy index and latched operation; a request is only taken in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= {IW{1'b0}};
      op_r  <= CTX_SAVE;
    end else if ((state_r == IDLE) && ctx_req) begin
      idx_r <= {IW{1'b0}};
      op_r  <= ctx_op;
    end else if (copying_s) begin
      idx_r <= idx_r + IW'(1'b1);
    end else begin
      idx_r <= idx_r;
      op_r  <= op_r;
    end
  end

  // GPR bank: restore copy wins; normal writes are already blocked while copying
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        gpr_r[i] <= {WIDTH{1'b0}};
      end
    end else if (copy_restore_s) begin
      gpr_r[idx_r] <= shadow_r[idx_r];
    end else if (gpr_wr_s) begin
      gpr_r[waddr[IW-1:0]] <= gpr_new_s;
    end
  end

  // Shadow bank: filled one entry per cycle during a save
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow_r[i] <= {WIDTH{1'b0}};
      end
    end else if (copy_save_s) begin
      shadow_r[idx_r] <= gpr_r[idx_r];
    end
  end

  // Special registers: updated regardless of engine activity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar_r   <= {WIDTH{1'b0}};
      mpage_r <= {IO_W{1'b0}};
      oreg_r  <= {IO_W{1'b0}};
    end else begin
      if (mar_wr_s) begin
        mar_r <= mar_new_s;
      end
      if (mpage_wr_s) begin
        mpage_r <= wdata[IO_W-1:0];
      end
      if (oreg_wr_s) begin
        oreg_r <= wdata[IO_W-1:0];
      end
    end
  end

  // Registered status pulses and engine flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oreg_stb_r <= 1'b0;
      wr_drop_r  <= 1'b0;
      ctx_busy_r <= 1'b0;
      ctx_done_r <= 1'b0;
    end else begin
      oreg_stb_r <= oreg_wr_s;
      wr_drop_r  <= drop_s;
      ctx_busy_r <= busy_nxt_s;
      ctx_done_r <= done_nxt_s;
    end
  end

  assign ctx_busy = ctx_busy_r;
  assign ctx_done = ctx_done_r;
  assign wr_drop  = wr_drop_r;
  assign mar      = mar_r;
  assign mpage    = mpage_r;
  assign oreg     = oreg_r;
  assign oreg_stb = oreg_stb_r;
  assign ireg     = ireg_s;

endmodule
